// File: rtl/tank_level_counter.sv
// Tank volume tracker: drains/refills a 3-bit consumed-volume level in prescaled steps,
// driving valve and pump and flagging full/empty/alarm. Level 0 = full tank, 7 = empty.
// Optional refill lockout after running dry: define TANK_REFILL_LOCKOUT_EN.
module tank_level_counter #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       irrigate,
  input  logic       refill,
  output logic [2:0] water_level,
  output logic       valve_open,
  output logic       pump_on,
  output logic       full,
  output logic       empty,
  output logic       alarm
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDraining,
    StFilling,
    StEmpty
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      level_q, level_d;
  logic [PreW-1:0] prescaler_q, prescaler_d;
  logic            step;
  logic            locked;

  assign step = (prescaler_q == PreMax);

`ifdef TANK_REFILL_LOCKOUT_EN
  logic lockout_q, lockout_d;

  // Lockout set on entering EMPTY, released once refilled down to level 3 or less.
  always_comb begin
    lockout_d = lockout_q;
    if (state_q != StEmpty && state_d == StEmpty) begin
      lockout_d = 1'b1;
    end else if (state_q == StFilling && level_d != level_q && level_d <= 3'd3) begin
      lockout_d = 1'b0;
    end
  end

  // Lockout flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lockout_q <= 1'b0;
    end else begin
      lockout_q <= lockout_d;
    end
  end

  assign locked = lockout_q;
`else
  assign locked = 1'b0;
`endif

  // Next-state and level update; a request-driven transition discards a coincident step.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      StIdle: begin
        if (refill && level_q != 3'd0) begin
          state_d = StFilling;
        end else if (irrigate && level_q != 3'd7 && !locked) begin
          state_d = StDraining;
        end
      end
      StDraining: begin
        if (refill) begin
          state_d = StFilling;
        end else if (!irrigate) begin
          state_d = StIdle;
        end else if (step) begin
          level_d = (level_q == 3'd7) ? 3'd7 : level_q + 3'd1;
          if (level_d == 3'd7) begin
            state_d = StEmpty;
          end
        end
      end
      StFilling: begin
        if (!refill) begin
          state_d = StIdle;
        end else if (step) begin
          level_d = (level_q == 3'd0) ? 3'd0 : level_q - 3'd1;
          if (level_d == 3'd0) begin
            state_d = StIdle;
          end
        end
      end
      StEmpty: begin
        if (refill) begin
          state_d = StFilling;
        end
      end
    endcase
  end

  // Prescaler runs only while draining/filling and restarts on any state change.
  always_comb begin
    prescaler_d = '0;
    if (state_d == state_q && (state_q == StDraining || state_q == StFilling) && !step) begin
      prescaler_d = prescaler_q + PreW'(1);
    end
  end

  // State, level and prescaler registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      level_q     <= 3'd0;
      prescaler_q <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      prescaler_q <= prescaler_d;
    end
  end

  assign water_level = level_q;
  assign valve_open  = (state_q == StDraining);
  assign pump_on     = (state_q == StFilling);
  assign full        = (level_q == 3'd0);
  assign empty       = (level_q == 3'd7);
  assign alarm       = (state_q == StEmpty) | locked;

endmodule

// File: tb/tb_tank_level_counter.sv
// Directed bench for tank_level_counter with TICK_DIV = 4.
module tb_tank_level_counter;

  logic       clock;
  logic       reset;
  logic       irrigate;
  logic       refill;
  logic [2:0] water_level;
  logic       valve_open;
  logic       pump_on;
  logic       full;
  logic       empty;
  logic       alarm;

  int checks = 0;
  int errors = 0;

`ifdef TANK_REFILL_LOCKOUT_EN
  localparam bit Lockout = 1'b1;
`else
  localparam bit Lockout = 1'b0;
`endif

  tank_level_counter #(.TICK_DIV(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .irrigate   (irrigate),
    .refill     (refill),
    .water_level(water_level),
    .valve_open (valve_open),
    .pump_on    (pump_on),
    .full       (full),
    .empty      (empty),
    .alarm      (alarm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset    = 1'b1;
    irrigate = 1'b0;
    refill   = 1'b0;
    #1;
    check("rst_level", water_level, 0);
    check("rst_full", full, 1);
    check("rst_empty", empty, 0);
    check("rst_valve", valve_open, 0);
    check("rst_pump", pump_on, 0);
    check("rst_alarm", alarm, 0);
    @(negedge clock);
    reset = 1'b0;

    // Async reset mid-drain at level 3
    irrigate = 1'b1;
    tick(13);
    check("pre_rst_level", water_level, 3);
    check("pre_rst_valve", valve_open, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_level", water_level, 0);
    check("mid_rst_full", full, 1);
    check("mid_rst_valve", valve_open, 0);
    irrigate = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Full drain 0 -> 7
    irrigate = 1'b1;
    tick(1);
    check("drain_valve", valve_open, 1);
    check("drain_lvl0", water_level, 0);
    tick(3);
    check("drain_hold0", water_level, 0);
    for (int k = 1; k <= 7; k++) begin
      tick((k == 1) ? 1 : 4);
      check("drain_lvl", water_level, k);
    end
    check("drain_empty", empty, 1);
    check("drain_alarm", alarm, 1);
    check("drain_valve_off", valve_open, 0);
    check("drain_full", full, 0);
    tick(3);
    check("empty_stay", water_level, 7);
    check("empty_valve", valve_open, 0);

    // Refill from EMPTY to full
    irrigate = 1'b0;
    refill   = 1'b1;
    tick(1);
    check("fill_pump", pump_on, 1);
    check("fill_lvl7", water_level, 7);
    check("fill_alarm0", alarm, Lockout);
    for (int k = 1; k <= 7; k++) begin
      tick(4);
      check("fill_lvl", water_level, 7 - k);
      check("fill_alarm", alarm, (Lockout && (7 - k) > 3) ? 1 : 0);
    end
    check("fill_done_pump", pump_on, 0);
    check("fill_done_full", full, 1);
    tick(8);
    check("refill_at_full_lvl", water_level, 0);
    check("refill_at_full_pump", pump_on, 0);

    // Priority: refill over irrigate at level 4
    refill   = 1'b0;
    irrigate = 1'b1;
    tick(17);
    check("prio_lvl4", water_level, 4);
    refill = 1'b1;
    tick(1);
    check("prio_pump", pump_on, 1);
    check("prio_valve", valve_open, 0);
    check("prio_lvl_hold", water_level, 4);
    tick(4);
    check("prio_lvl3", water_level, 3);
    refill   = 1'b0;
    irrigate = 1'b0;
    tick(1);
    check("prio_idle_pump", pump_on, 0);

    // Coincident drop at level 2
    refill = 1'b1;
    tick(5);
    check("co_lvl2", water_level, 2);
    refill = 1'b0;
    tick(1);
    irrigate = 1'b1;
    tick(4);
    check("co_valve", valve_open, 1);
    check("co_lvl_pre", water_level, 2);
    irrigate = 1'b0;
    tick(1);
    check("co_lvl_kept", water_level, 2);
    check("co_valve_off", valve_open, 0);
    check("co_prescaler", dut.prescaler_q, 0);
    tick(3);
    check("co_lvl_idle", water_level, 2);

    // Lockout behaviour after running dry
    irrigate = 1'b1;
    tick(21);
    check("lo_empty", empty, 1);
    irrigate = 1'b0;
    refill   = 1'b1;
    tick(9);
    check("lo_lvl5", water_level, 5);
    refill   = 1'b0;
    irrigate = 1'b1;
    tick(3);
    check("lo_lvl5_hold", water_level, 5);
    check("lo_valve", valve_open, Lockout ? 0 : 1);
    check("lo_alarm", alarm, Lockout ? 1 : 0);
    if (Lockout) begin
      irrigate = 1'b0;
      refill   = 1'b1;
      tick(9);
      check("lo_lvl3", water_level, 3);
      check("lo_alarm_clr", alarm, 0);
      refill   = 1'b0;
      irrigate = 1'b1;
      tick(3);
      check("lo_drain_ok", valve_open, 1);
      check("lo_drain_lvl", water_level, 3);
    end else begin
      tick(3);
      check("nolo_lvl6", water_level, 6);
      check("nolo_valve", valve_open, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tank_level_counter.md
# tank_level_counter

Sequential tank-volume tracker that produces the 3-bit `water_level` consumed by the tank-emptying column decoder on the LED matrix. It times irrigation drain and supply refill with a prescaled step and sequences valve and pump. It holds the level as a consumed-volume count: 0 = full tank, 7 = empty tank. It also flags full, empty and alarm conditions for the control panel.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per one level step. Legal range is ≥ 2; the prescaler width is $clog2(TICK_DIV).
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `irrigate`  in  1  level request: open valve and drain the tank.
- `refill`  in  1  level request: run pump and fill the tank. Has priority over `irrigate`.
- `water_level`  out  3  consumed volume, 0 (full) … 7 (empty). Feeds the column decoder directly.
- `valve_open`  out  1  high while in DRAINING.
- `pump_on`  out  1  high while in FILLING.
- `full`  out  1  `water_level == 0`.
- `empty`  out  1  `water_level == 7`.
- `alarm`  out  1  empty / lockout indication; see Configuration.

## Operation
States are IDLE, DRAINING, FILLING and EMPTY. Transitions are evaluated every edge, in priority order.

- **IDLE**
  - If `refill` and level ≠ 0, go to FILLING.
  - Else if `irrigate` and level ≠ 7 and not locked out, go to DRAINING.
  - Otherwise stay in IDLE.
- **DRAINING**
  - If `refill`, go to FILLING.
  - Else if `!irrigate`, go to IDLE.
  - Else on a step, level is incremented by 1. If the new level is 7, go to EMPTY.
- **FILLING**
  - If `!refill`, go to IDLE.
  - Else on a step, level is decremented by 1. If the new level is 0, go to IDLE.
- **EMPTY**
  - `valve_open` is forced to 0. `irrigate` is ignored.
  - If `refill`, go to FILLING. Otherwise stay in EMPTY.

Step generation and arithmetic:
- The prescaler counts only in DRAINING and FILLING. It is cleared to 0 on every state change and in IDLE/EMPTY.
- A step fires on the edge where the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
- If a step and a state transition coincide on the same edge, the transition wins. The step is discarded and the level is unchanged.
- Level arithmetic is saturating 3-bit. It never wraps 7→0 or 0→7.
- `full`, `empty`, `valve_open`, `pump_on` and `alarm` are decoded from registered state and level. There are no combinational paths from inputs to outputs.

## Timing
- Reset values: state IDLE, prescaler 0, `water_level` 0, `valve_open` 0, `pump_on` 0, `full` 1, `empty` 0, `alarm` 0, lockout flag 0.
- Reset asserted mid-drain or mid-fill returns the block immediately to the reset values; the level is not retained.
- A request sampled at edge E0 moves the state at E0. `valve_open` / `pump_on` are high in the cycle after E0.
- First level change occurs at edge E0+TICK_DIV, then every TICK_DIV cycles while the request is held.
- Full drain from 0 to 7 takes 7·TICK_DIV cycles after entry. EMPTY is entered on the same edge at which the level becomes 7.
- Dropping a request takes effect on the next edge. The partial prescaler count is lost.
- `refill` held with level 0 in IDLE: the block stays in IDLE and `pump_on` stays 0.

## Configuration
- Macro: `TANK_REFILL_LOCKOUT_EN`.
- **Defined:**
  - A lockout flag is set on entry to EMPTY.
  - It is cleared on the edge where the level becomes ≤ 3 during FILLING.
  - While the flag is set, IDLE ignores `irrigate`.
  - `alarm` = (state == EMPTY) | lockout.
- **Undefined:**
  - No lockout flag exists.
  - `irrigate` is honoured whenever level < 7.
  - `alarm` = (state == EMPTY).

## Test plan
Use TICK_DIV = 4 for all scenarios.

1. **Reset:** assert `reset` mid-drain at level 3 → all outputs are at reset values asynchronously: `water_level` 0, `full` 1, `valve_open` 0.
2. **Drain:** hold `irrigate` from level 0 →
   - `valve_open` goes to 1.
   - Level is 1 at E0+4, 2 at E0+8, …, 7 at E0+28.
   - At E0+28 the state is EMPTY, `empty` 1, `alarm` 1, `valve_open` 0.
3. **Priority:** at level 4 in DRAINING, assert `refill` together with `irrigate` → state FILLING next edge, `pump_on` 1, level 3 four cycles later.
4. **Coincident drop:** drop `irrigate` on the edge where the prescaler equals 3 at level 2 → state IDLE, level stays 2, prescaler 0.
5. **Refill to full:** from EMPTY, hold `refill` → level reaches 0 after 28 cycles, state IDLE, `pump_on` 0, `full` 1. Further `refill` has no effect.
6. **Lockout:** with `TANK_REFILL_LOCKOUT_EN`, from EMPTY refill to level 5, then release `refill` and assert `irrigate` →
   - The block stays in IDLE with `alarm` 1.
   - After refilling to level 3, `irrigate` enters DRAINING.
   - Without the macro, `irrigate` at level 5 enters DRAINING.
